sigmoid_arbiter: RTL and testbench
==================================

SIGMOID_ARBITER -- requirements
Module: sigmoid_arbiter

Interface
REQ-001 SHALL have parameter BITWIDTH, default 18, operand/result width.
REQ-002 SHALL have parameter N_REQ, default 3, number of requesters (LSTM gates i, f, o).
REQ-003 SHALL have parameter SIG_LATENCY, default 2, shared sigmoid pipeline depth in cycles.
REQ-004 SHALL have port clock  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  in  N_REQ  per-requester operand valid.
REQ-007 SHALL have port req_data  in  N_REQ*BITWIDTH  packed operands; requester i in slice i.
REQ-008 SHALL have port req_ready  out  N_REQ  one-hot grant.
REQ-009 SHALL have port flush  in  1  stop accepting and drain pipeline.
REQ-010 SHALL have port flush_done  out  1  pipeline empty while flushing.
REQ-011 SHALL have port sig_operand  out  BITWIDTH  registered operand to shared sigmoid.
REQ-012 SHALL have port sig_result  in  BITWIDTH  sigmoid output, SIG_LATENCY cycles after sig_operand.
REQ-013 SHALL have port resp_valid  out  N_REQ  one-hot result strobe.
REQ-014 SHALL have port resp_data  out  BITWIDTH  result, equals sig_result.
REQ-015 SHALL have port grant_count  out  N_REQ*32  per-requester accepted-operand counters.

Function
REQ-016 SHALL implement FSM IDLE, ISSUE, DRAIN; IDLE->ISSUE on any req_valid with flush low; ISSUE->IDLE when no req_valid and tag pipe empty; IDLE/ISSUE->DRAIN on flush; DRAIN->IDLE when flush low and tag pipe empty.
REQ-017 SHALL, in IDLE or ISSUE with flush low, assert req_ready for exactly one valid requester chosen round-robin starting at last_grant+1 modulo N_REQ; req_ready SHALL be zero when no requester is valid or flush is high.
REQ-018 SHALL treat req_valid[i] & req_ready[i] as acceptance; requesters hold valid and data until accepted.
REQ-019 SHALL, on acceptance, register req_data slice into sig_operand, update last_grant, and push {valid=1, id} into a SIG_LATENCY+1 deep tag shift register; otherwise push valid=0 and hold sig_operand.
REQ-020 SHALL assert resp_valid[id] for one cycle exactly 1+SIG_LATENCY cycles after the acceptance edge; no response backpressure.
REQ-021 SHALL sustain one acceptance per cycle with back-to-back responses in acceptance order.
REQ-022 SHALL assert flush_done in DRAIN only when the tag pipe holds no valid entry; in-flight results still deliver during DRAIN.
REQ-023 SHALL allow IDLE->ISSUE in the same cycle a request arrives (zero-cycle grant latency).
REQ-024 SHALL wrap grant_count at 2^32-1 -> 0.

Reset
REQ-025 SHALL on reset: state IDLE, last_grant = N_REQ-1 (requester 0 first), tag pipe all invalid, sig_operand 0, req_ready 0, resp_valid 0, flush_done 0, grant_count 0.
REQ-026 SHALL discard in-flight operands when reset asserts mid-operation; no resp_valid in the cycle after reset deasserts.

Configuration
REQ-027 SHALL include grant counters only with macro SIGMOID_ARB_STATS_EN defined; without it grant_count SHALL be constant 0 and no counter flops exist.

Structure
REQ-028 SHALL place state enum, ID width ($clog2(N_REQ)) and default BITWIDTH in package sigmoid_arb_pkg.
REQ-029 SHALL isolate round-robin pick in sub-module rr_pick (valid vector, last_grant -> one-hot grant); sigmoid stays external.

Verification
REQ-030 Bench model: sig_result = sig_operand XOR 0x3FFFF delayed SIG_LATENCY cycles.
REQ-031 Single req: req_valid=001, data0=0x00100 -> req_ready=001 same cycle, resp_valid=001 3 cycles later, resp_data=0x3FEFF.
REQ-032 All valid constantly after reset -> grants 001,010,100,001 on consecutive cycles; responses same order 3 cycles later.
REQ-033 flush high with 2 in flight -> req_ready=0, both responses delivered, flush_done high the cycle after the last.
REQ-034 reset pulse one cycle after acceptance -> no resp_valid ever for that operand; grant_count=0.
REQ-035 With SIGMOID_ARB_STATS_EN: 10 grants to req 1 -> grant_count slice 1 = 10; without macro -> all 0.

Source files
------------

// File: rtl/sigmoid_arb_pkg.sv
// Shared types and sizing helpers for the sigmoid arbiter.
// Imported by sigmoid_arbiter and rr_pick.
package sigmoid_arb_pkg;

  localparam int DEF_BITWIDTH = 18;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Requester id width, never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sigmoid_arbiter_rr_pick.sv
// Round-robin picker: one-hot grant to the first valid
// requester after last, wrapping modulo N_REQ.
module rr_pick
  import sigmoid_arb_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int IDW   = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDW-1:0]   last,
  output logic [N_REQ-1:0] grant
);

  int   idx;
  logic found;

  // Scan from last+1 and keep only the first hit.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sigmoid_arbiter.sv
// Shares one external sigmoid pipeline among N_REQ requesters.
// Optional grant counters: define SIGMOID_ARB_STATS_EN.
module sigmoid_arbiter
  import sigmoid_arb_pkg::*;
#(
  parameter int BITWIDTH    = DEF_BITWIDTH,
  parameter int N_REQ       = 3,
  parameter int SIG_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*BITWIDTH-1:0] req_data,
  output logic [N_REQ-1:0]      req_ready,
  input  logic                  flush,
  output logic                  flush_done,
  output logic [BITWIDTH-1:0]   sig_operand,
  input  logic [BITWIDTH-1:0]   sig_result,
  output logic [N_REQ-1:0]      resp_valid,
  output logic [BITWIDTH-1:0]   resp_data,
  output logic [N_REQ*32-1:0]   grant_count
);

  localparam int IDW = id_w(N_REQ);

  state_t               state;
  logic [IDW-1:0]       last_grant;
  logic [SIG_LATENCY:0] tag_v;
  logic [IDW-1:0]       tag_id [SIG_LATENCY+1];
  logic                 tag_busy;
  logic                 can_grant;
  logic [N_REQ-1:0]     pick;
  logic                 accept;
  logic [IDW-1:0]       gid;

  assign tag_busy  = |tag_v;
  assign can_grant = !reset && !flush
                     && (state != DRAIN);

  rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
    .valid (req_valid & {N_REQ{can_grant}}),
    .last  (last_grant),
    .grant (pick)
  );

  assign req_ready = pick;
  assign accept    = |pick;
  assign resp_data = sig_result;
  assign flush_done = !reset && (state == DRAIN)
                      && !tag_busy;

  // Encode the one-hot grant into a requester id.
  always_comb begin
    gid = '0;
    for (int i = 0; i < N_REQ; i++)
      if (pick[i]) gid = IDW'(i);
  end

  // Strobe the owner of the tag leaving the pipe.
  always_comb begin
    resp_valid = '0;
    if (!reset && tag_v[SIG_LATENCY])
      resp_valid[tag_id[SIG_LATENCY]] = 1'b1;
  end

  // Control FSM plus round-robin pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= IDW'(N_REQ - 1);
    end else begin
      if (accept) last_grant <= gid;
      unique case (state)
        IDLE: begin
          if (flush) state <= DRAIN;
          else if (|req_valid) state <= ISSUE;
        end
        ISSUE: begin
          if (flush) state <= DRAIN;
          else if (!(|req_valid) && !tag_busy)
            state <= IDLE;
        end
        DRAIN: begin
          if (!flush && !tag_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand register feeding the shared sigmoid.
  always_ff @(posedge clock) begin
    if (reset)
      sig_operand <= '0;
    else if (accept)
      sig_operand <=
        req_data[int'(gid)*BITWIDTH +: BITWIDTH];
  end

  // Tag pipe tracks which requester owns each stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_v <= '0;
      for (int k = 0; k <= SIG_LATENCY; k++)
        tag_id[k] <= '0;
    end else begin
      tag_v[0]  <= accept;
      tag_id[0] <= gid;
      for (int k = 1; k <= SIG_LATENCY; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

`ifdef SIGMOID_ARB_STATS_EN
  logic [N_REQ*32-1:0] cnt;

  // Per-requester accepted-operand counters, wrap at 2^32.
  always_ff @(posedge clock) begin
    if (reset)
      cnt <= '0;
    else if (accept)
      cnt[int'(gid)*32 +: 32] <=
        cnt[int'(gid)*32 +: 32] + 32'd1;
  end

  assign grant_count = cnt;
`else
  assign grant_count = '0;
`endif

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Scoreboard bench for sigmoid_arbiter with an XOR
// stand-in for the shared sigmoid pipeline.
module tb_sigmoid_arbiter;

  localparam int W = 18;
  localparam int N = 3;
  localparam int L = 2;
  localparam logic [W-1:0] MASK = 18'h3FFFF;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N*W-1:0]   req_data = '0;
  logic             flush = 1'b0;
  logic [N-1:0]     req_ready;
  logic             flush_done;
  logic [W-1:0]     sig_operand;
  logic [W-1:0]     sig_result;
  logic [N-1:0]     resp_valid;
  logic [W-1:0]     resp_data;
  logic [N*32-1:0]  grant_count;

  logic [W-1:0] sp0, sp1;

  typedef struct {
    int           due;
    int           id;
    logic [W-1:0] data;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int scyc = 0;
  logic [N-1:0] rdy_s;
  logic [N-1:0] rv_s;
  logic         fd_s;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    sp0 <= sig_operand ^ MASK;
    sp1 <= sp0;
  end
  assign sig_result = sp1;

  sigmoid_arbiter #(
    .BITWIDTH(W), .N_REQ(N), .SIG_LATENCY(L)
  ) dut (
    .clock       (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .flush       (flush),
    .flush_done  (flush_done),
    .sig_operand (sig_operand),
    .sig_result  (sig_result),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .grant_count (grant_count)
  );

  // One clock: sample mid-cycle, score, return after edge.
  task automatic cycle();
    exp_t e;
    logic [N-1:0] oh;
    @(negedge clk);
    scyc  = cyc;
    rdy_s = req_ready;
    rv_s  = resp_valid;
    fd_s  = flush_done;
    if (!reset)
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i]) begin
          e.due  = cyc + 1 + L;
          e.id   = i;
          e.data = req_data[i*W +: W] ^ MASK;
          q.push_back(e);
        end
    if (resp_valid !== '0) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected got %b cyc %0d",
                 resp_valid, cyc);
      end else begin
        e = q.pop_front();
        oh = '0;
        oh[e.id] = 1'b1;
        if (resp_valid !== oh || resp_data !== e.data
            || cyc != e.due) begin
          errors++;
          $display("FAIL resp got %b/%h@%0d want %b/%h@%0d",
                   resp_valid, resp_data, cyc,
                   oh, e.data, e.due);
        end
      end
    end
    if (q.size() > 0 && q[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL resp_missing got none want id %0d@%0d",
               q[0].id, q[0].due);
      void'(q.pop_front());
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    flush = 1'b0;
    q.delete();
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 3'b111;
    req_data = {18'h00333, 18'h00222, 18'h00111};
    cycle();
    cycle();
    checks++;
    if (rdy_s !== '0 || rv_s !== '0 || fd_s !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs got %b %b %b want 0 0 0",
               rdy_s, rv_s, fd_s);
    end
    checks++;
    if (sig_operand !== '0 || grant_count !== '0) begin
      errors++;
      $display("FAIL reset_regs got %h %h want 0 0",
               sig_operand, grant_count);
    end
    reset = 1'b0;
    cycle();
    checks++;
    if (rdy_s !== 3'b001) begin
      errors++;
      $display("FAIL reset_first got %b want 001", rdy_s);
    end
    req_valid = '0;
    drain(5);
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 3'b001;
    req_data = '0;
    req_data[W-1:0] = 18'h00100;
    cycle();
    checks++;
    if (rdy_s !== 3'b001) begin
      errors++;
      $display("FAIL single_ready got %b want 001", rdy_s);
    end
    req_valid = '0;
    cycle();
    cycle();
    cycle();
    checks++;
    if (rv_s !== 3'b001 || resp_data !== 18'h3FEFF) begin
      errors++;
      $display("FAIL single_resp got %b %h want 001 3feff",
               rv_s, resp_data);
    end
    drain(2);
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] want [4];
    want[0] = 3'b001;
    want[1] = 3'b010;
    want[2] = 3'b100;
    want[3] = 3'b001;
    do_reset();
    req_valid = 3'b111;
    req_data = {18'h0A0A0, 18'h05050, 18'h12345};
    for (int k = 0; k < 4; k++) begin
      cycle();
      checks++;
      if (rdy_s !== want[k]) begin
        errors++;
        $display("FAIL rr_grant%0d got %b want %b",
                 k, rdy_s, want[k]);
      end
      for (int i = 0; i < N; i++)
        if (rdy_s[i])
          req_data[i*W +: W] = W'($urandom);
    end
    req_valid = '0;
    drain(6);
  endtask

  task automatic test_flush();
    int last_resp;
    int fd_at;
    int nresp;
    bit rdy_bad;
    last_resp = -1;
    fd_at = -1;
    nresp = 0;
    rdy_bad = 1'b0;
    do_reset();
    req_valid = 3'b011;
    req_data = {18'h00000, 18'h1F00F, 18'h00ABC};
    cycle();
    cycle();
    checks++;
    if (rdy_s !== 3'b010) begin
      errors++;
      $display("FAIL flush_pre got %b want 010", rdy_s);
    end
    flush = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (rdy_s !== '0) rdy_bad = 1'b1;
      if (rv_s !== '0) begin
        last_resp = scyc;
        nresp++;
      end
      if (fd_s && fd_at < 0) fd_at = scyc;
    end
    checks++;
    if (rdy_bad) begin
      errors++;
      $display("FAIL flush_ready got nonzero want 000");
    end
    checks++;
    if (nresp != 2) begin
      errors++;
      $display("FAIL flush_nresp got %0d want 2", nresp);
    end
    checks++;
    if (last_resp < 0 || fd_at != last_resp + 1) begin
      errors++;
      $display("FAIL flush_done_at got %0d want %0d",
               fd_at, last_resp + 1);
    end
    flush = 1'b0;
    req_valid = '0;
    cycle();
    cycle();
    req_valid = 3'b100;
    cycle();
    checks++;
    if (rdy_s !== 3'b100) begin
      errors++;
      $display("FAIL flush_resume got %b want 100", rdy_s);
    end
    req_valid = '0;
    drain(5);
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    do_reset();
    req_valid = 3'b001;
    req_data = '0;
    req_data[W-1:0] = 18'h2AAAA;
    cycle();
    req_valid = '0;
    cycle();
    reset = 1'b1;
    q.delete();
    cycle();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (rv_s !== '0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL resetmid_resp got %0d want 0", seen);
    end
    checks++;
    if (grant_count !== '0) begin
      errors++;
      $display("FAIL resetmid_cnt got %h want 0",
               grant_count);
    end
  endtask

  task automatic test_stats();
    int g;
    logic [31:0] want1;
`ifdef SIGMOID_ARB_STATS_EN
    want1 = 32'd10;
`else
    want1 = 32'd0;
`endif
    g = 0;
    do_reset();
    req_valid = 3'b010;
    req_data = {18'h00000, 18'h00777, 18'h00000};
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (rdy_s === 3'b010) g++;
      req_data[W +: W] = W'($urandom);
    end
    req_valid = '0;
    drain(5);
    checks++;
    if (g != 10) begin
      errors++;
      $display("FAIL stats_grants got %0d want 10", g);
    end
    checks++;
    if (grant_count[32 +: 32] !== want1) begin
      errors++;
      $display("FAIL stats_cnt1 got %0d want %0d",
               grant_count[32 +: 32], want1);
    end
    checks++;
    if (grant_count[0 +: 32] !== '0
        || grant_count[64 +: 32] !== '0) begin
      errors++;
      $display("FAIL stats_cnt02 got %h want 0",
               grant_count);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_stats();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL sb_empty got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
